tb_rsc_encoder: RTL and testbench



---
 rtl/tb_rsc_encoder_if.sv | 38 +++
 rtl/tb_rsc_encoder.sv | 165 ++++++++++++++++
 tb/tb_tb_rsc_encoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tb_rsc_encoder_if.sv
// ============================================================================
// Module   : tb_rsc_encoder_if
// Purpose  : Handshake and symbol bus of the RSC constituent encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tb_rsc_encoder_if #(
    parameter int LEN_W = 13
);
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             data_valid_i;
    logic             data_ready_o;
    logic             data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [7:0]       out_sys_o;
    logic [7:0]       out_par_o;
    logic             out_tail_o;
    logic             out_last_o;
    logic             done_o;

    modport slave (
        input  start_i, len_i, data_valid_i, data_i, out_ready_i,
        output busy_o, data_ready_o, out_valid_o, out_sys_o, out_par_o,
               out_tail_o, out_last_o, done_o
    );

    modport master (
        output start_i, len_i, data_valid_i, data_i, out_ready_i,
        input  busy_o, data_ready_o, out_valid_o, out_sys_o, out_par_o,
               out_tail_o, out_last_o, done_o
    );
endinterface

`default_nettype wire

// File: rtl/tb_rsc_encoder.sv
// ============================================================================
// Module   : tb_rsc_encoder
// Purpose  : 8-state RSC encoder (g0=13, g1=15 octal), rate 1/2, trellis
//            termination. Optional macro TB_ENC_LLR_MAP_EN maps bits to LLRs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rsc_encoder #(
    parameter int         LEN_W   = 13,
    parameter logic [7:0] LLR_MAG = 8'd64
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    tb_rsc_encoder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_TAIL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] c_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_n;
    logic [2:0]       r_s, w_s_n;          // {s3,s2,s1}
    logic [LEN_W-1:0] r_k, w_k_n;
    logic [LEN_W-1:0] r_cnt, w_cnt_n;
    logic [1:0]       r_tcnt, w_tcnt_n;
    logic             r_valid, w_valid_n;
    logic [7:0]       r_sys, w_sys_n;
    logic [7:0]       r_par, w_par_n;
    logic             r_tail, w_tail_n;
    logic             r_last, w_last_n;

    logic w_free, w_load, w_d, w_f, w_p, w_data_ready, w_done;

`ifdef TB_ENC_LLR_MAP_EN
    function automatic logic [7:0] f_map(input logic b);
        return b ? (~LLR_MAG + 8'd1) : LLR_MAG;
    endfunction
`else
    logic w_unused_mag;
    assign w_unused_mag = ^LLR_MAG;

    function automatic logic [7:0] f_map(input logic b);
        return {7'b0, b};
    endfunction
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_s     <= 3'b000;
            r_k     <= '0;
            r_cnt   <= '0;
            r_tcnt  <= 2'd0;
            r_valid <= 1'b0;
            r_sys   <= 8'd0;
            r_par   <= 8'd0;
            r_tail  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_s     <= w_s_n;
            r_k     <= w_k_n;
            r_cnt   <= w_cnt_n;
            r_tcnt  <= w_tcnt_n;
            r_valid <= w_valid_n;
            r_sys   <= w_sys_n;
            r_par   <= w_par_n;
            r_tail  <= w_tail_n;
            r_last  <= w_last_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_s_n        = r_s;
        w_k_n        = r_k;
        w_cnt_n      = r_cnt;
        w_tcnt_n     = r_tcnt;
        w_valid_n    = r_valid;
        w_sys_n      = r_sys;
        w_par_n      = r_par;
        w_tail_n     = r_tail;
        w_last_n     = r_last;
        w_data_ready = 1'b0;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_free       = !r_valid || bus.out_ready_i;

        // In TAIL the input is chosen so the feedback cancels to zero
        w_d = (r_state == S_TAIL) ? (r_s[1] ^ r_s[2]) : bus.data_i;
        w_f = w_d ^ r_s[1] ^ r_s[2];
        w_p = w_f ^ r_s[0] ^ r_s[2];

        if (r_valid && bus.out_ready_i)
            w_valid_n = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start_i && (bus.len_i != '0)) begin
                    w_k_n     = bus.len_i;
                    w_s_n     = 3'b000;
                    w_cnt_n   = '0;
                    w_state_n = S_ENC;
                end
            end
            S_ENC: begin
                w_data_ready = w_free;
                if (bus.data_valid_i && w_free) begin
                    w_load   = 1'b1;
                    w_tail_n = 1'b0;
                    w_last_n = 1'b0;
                    w_cnt_n  = r_cnt + c_ONE;
                    if (r_cnt == (r_k - c_ONE)) begin
                        w_tcnt_n  = 2'd0;
                        w_state_n = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (w_free) begin
                    w_load   = 1'b1;
                    w_tail_n = 1'b1;
                    w_tcnt_n = r_tcnt + 2'd1;
                    if (r_tcnt == 2'd2) begin
                        w_last_n  = 1'b1;
                        w_state_n = S_DRAIN;
                    end
                end
            end
            default: begin
                if (r_valid && bus.out_ready_i) begin
                    w_done    = 1'b1;
                    w_tail_n  = 1'b0;
                    w_last_n  = 1'b0;
                    w_state_n = S_IDLE;
                end
            end
        endcase

        if (w_load) begin
            w_valid_n = 1'b1;
            w_s_n     = {r_s[1], r_s[0], w_f};
            w_sys_n   = f_map(w_d);
            w_par_n   = f_map(w_p);
        end
    end

    assign bus.busy_o       = (r_state != S_IDLE);
    assign bus.data_ready_o = w_data_ready;
    assign bus.out_valid_o  = r_valid;
    assign bus.out_sys_o    = r_sys;
    assign bus.out_par_o    = r_par;
    assign bus.out_tail_o   = r_tail;
    assign bus.out_last_o   = r_last;
    assign bus.done_o       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_tb_rsc_encoder.sv
// ============================================================================
// Module   : tb_tb_rsc_encoder
// Purpose  : Scoreboard bench for the RSC encoder with hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_rsc_encoder;

    localparam int LEN_W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tb_rsc_encoder_if #(.LEN_W(LEN_W)) bus();

    tb_rsc_encoder #(.LEN_W(LEN_W), .LLR_MAG(8'd64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] sys;
        logic [7:0] par;
        logic       tail;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic tog_mode = 1'b0;

    function automatic logic [7:0] sym(input logic b);
`ifdef TB_ENC_LLR_MAP_EN
        return b ? 8'hC0 : 8'h40;
`else
        return {7'b0, b};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Tables are written in output order, first pair in the MSB position
    task automatic push_block(input logic [9:0] sb, input logic [9:0] pb,
                              input int n, input int n_push);
        exp_t e;
        for (int i = 0; i < n_push; i++) begin
            e.sys  = sym(sb[n-1-i]);
            e.par  = sym(pb[n-1-i]);
            e.tail = (i >= n - 3);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_block(input int k, input logic [15:0] bits,
                             input bit mid_start, input int n_feed);
        logic hs;
        int   cyc;
        bus.start_i = 1'b1;
        bus.len_i   = LEN_W'(k);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int i = 0; i < n_feed; i++) begin
            bus.data_valid_i = 1'b1;
            bus.data_i       = bits[k-1-i];
            if (mid_start && i == 1) begin
                bus.start_i = 1'b1;
                bus.len_i   = LEN_W'(2);
            end
            cyc = 0;
            do begin
                @(negedge clk);
                hs = bus.data_ready_o;
                @(posedge clk); #1;
                bus.start_i = 1'b0;
                cyc++;
            end while (!hs && cyc < 200);
            if (!hs) begin
                n_total++;
                $display("FAIL data_handshake_timeout: bit %0d not accepted, expected accept", i);
            end
        end
        bus.data_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (bus.busy_o && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_idle"}, 32'(bus.busy_o), 32'd0);
        check({name, "_final_state"}, 32'(dut.r_s), 32'd0);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: pops one expectation per accepted pair
    logic prev_stall = 1'b0;
    logic prev_done  = 1'b0;
    exp_t prev_out;

    always @(negedge clk) begin
        exp_t e, cur;
        cur = '{sys: bus.out_sys_o, par: bus.out_par_o,
                tail: bus.out_tail_o, last: bus.out_last_o};
        if (prev_done) check("busy_after_done", 32'(bus.busy_o), 32'd0);
        if (prev_stall) begin
            check("stall_valid_held", 32'(bus.out_valid_o), 32'd1);
            check("stall_outputs_held", 32'(cur), 32'(prev_out));
        end
        if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b0)
            check("data_ready_in_stall", 32'(bus.data_ready_o), 32'd0);
        if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pair: sys %0h par %0h, expected no pair",
                         bus.out_sys_o, bus.out_par_o);
            end else begin
                e = exp_q.pop_front();
                check("pair", 32'(cur), 32'(e));
                check("done_with_last", 32'(bus.done_o), 32'(e.last));
            end
        end else if (bus.done_o !== 1'b0) begin
            check("spurious_done", 32'(bus.done_o), 32'd0);
        end
        prev_stall = (bus.out_valid_o === 1'b1) && (bus.out_ready_i === 1'b0) && !rst;
        prev_done  = (bus.done_o === 1'b1) && !rst;
        prev_out   = cur;
    end

    initial begin
        logic [3:0] pat;
        int         idx;
        pat = 4'b1001;
        idx = 0;
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tog_mode) begin
                bus.out_ready_i = pat[3 - (idx % 4)];
                idx++;
            end else begin
                bus.out_ready_i = 1'b1;
                idx = 0;
            end
        end
    end

    initial begin
        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.data_valid_i = 1'b0;
        bus.data_i       = 1'b0;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({bus.busy_o, bus.out_valid_o, bus.data_ready_o, bus.done_o,
                   bus.out_tail_o, bus.out_last_o, bus.out_sys_o, bus.out_par_o}), 32'd0);
        check("reset_state", 32'(dut.r_s), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // K=4, bits 1011, free-flowing output
        push_block(10'b1011000, 10'b1101000, 7, 7);
        run_block(4, 16'b1011, 1'b0, 4);
        wait_idle("k4");

        // K=1, bit 1
        push_block(10'b1011, 10'b1101, 4, 4);
        run_block(1, 16'b1, 1'b0, 1);
        wait_idle("k1");

        // Zero-length start is ignored
        bus.start_i = 1'b1;
        bus.len_i   = '0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0_busy", 32'(bus.busy_o), 32'd0);
            @(posedge clk); #1;
        end

        // K=4 under toggling backpressure
        tog_mode = 1'b1;
        push_block(10'b1011000, 10'b1101000, 7, 7);
        run_block(4, 16'b1011, 1'b0, 4);
        wait_idle("k4_stall");
        tog_mode = 1'b0;
        @(posedge clk); #1;

        // start_i during ENC is ignored
        push_block(10'b1011000, 10'b1101000, 7, 7);
        run_block(4, 16'b1011, 1'b1, 4);
        wait_idle("k4_midstart");
        repeat (3) @(posedge clk);
        #1;
        check("midstart_no_restart", 32'(bus.busy_o), 32'd0);

        // Reset after two of four bits aborts the block
        push_block(10'b1011000, 10'b1101000, 7, 2);
        run_block(4, 16'b1011, 1'b0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        check("abort_valid", 32'(bus.out_valid_o), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        check("abort_state", 32'(dut.r_s), 32'd0);

        push_block(10'b1011, 10'b1101, 4, 4);
        run_block(1, 16'b1, 1'b0, 1);
        wait_idle("k1_after_abort");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
